// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the seven-segment scanner: digit count, segment codes and off patterns.
// Segment codes are active-low and packed {g,f,e,d,c,b,a}.
package sevseg_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment code.
module hex_to_7seg
   import sevseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_LUT[nibble];
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed seven-segment driver with frame-aligned display updates.
// Define SEVSEG_BLANK_EN to blank leading zero digits (digit 0 always stays lit).
module seven_seg_scanner
   import sevseg_pkg::*;
#(
   parameter int DIGIT_TICKS = 100000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic [6:0]  cathode,
   output logic [7:0]  anode,
   output logic        frame_done,
   output logic [31:0] shown_value
);

   localparam int TICK_W = $clog2(DIGIT_TICKS + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);

   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]        digit_q, digit_d;
   logic [31:0]       disp_q, disp_d;
   logic [31:0]       pend_q, pend_d;
   logic              pend_valid_q, pend_valid_d;
   logic [6:0]        cathode_q, cathode_d;
   logic [7:0]        anode_q, anode_d;
   logic              frame_done_q, frame_done_d;

   logic              tick_wrap;
   logic              frame_wrap;
   logic              blank;
   logic [6:0]        seg_code;

   hex_to_7seg u_hex_to_7seg (
      .nibble (disp_q[{digit_q, 2'b00} +: 4]),
      .seg    (seg_code)
   );

`ifdef SEVSEG_BLANK_EN
   logic [2:0] msd;

   // Highest nonzero nibble; an all-zero value still keeps digit 0 lit.
   always_comb begin
      msd = 3'd0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (disp_q[4*i +: 4] != 4'h0) msd = 3'(i);
      end
      blank = (digit_q > msd);
   end
`else
   always_comb begin
      blank = 1'b0;
   end
`endif

   always_comb begin
      tick_wrap    = (tick_cnt_q == TICK_LAST);
      frame_wrap   = tick_wrap && (digit_q == 3'(NUM_DIGITS - 1));

      tick_cnt_d   = tick_wrap ? '0 : tick_cnt_q + 1'b1;
      digit_d      = tick_wrap ? digit_q + 3'd1 : digit_q;
      disp_d       = disp_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;

      // Commit uses the old pend; a write on the wrap cycle waits for the next frame.
      if (frame_wrap && pend_valid_q) begin
         disp_d       = pend_q;
         pend_valid_d = 1'b0;
      end
      if (wr_en) begin
         pend_d       = wr_data;
         pend_valid_d = 1'b1;
      end

      frame_done_d = frame_wrap;
      anode_d      = blank ? AN_OFF  : ~(8'b1 << digit_q);
      cathode_d    = blank ? SEG_OFF : seg_code;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q   <= '0;
         digit_q      <= 3'd0;
         disp_q       <= 32'h0;
         pend_q       <= 32'h0;
         pend_valid_q <= 1'b0;
         cathode_q    <= SEG_OFF;
         anode_q      <= AN_OFF;
         frame_done_q <= 1'b0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         digit_q      <= digit_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         cathode_q    <= cathode_d;
         anode_q      <= anode_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign cathode     = cathode_q;
   assign anode       = anode_q;
   assign frame_done  = frame_done_q;
   assign shown_value = disp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner with DIGIT_TICKS=4.
// Expected segment patterns come from a bench-side copy of the hex font and a blanking model.
module tb_seven_seg_scanner;

   localparam int TICKS = 4;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [6:0]  cathode;
   logic [7:0]  anode;
   logic        frame_done;
   logic [31:0] shown_value;

   int error_count;
   int check_count;

   logic [6:0] font [16];

   seven_seg_scanner #(.DIGIT_TICKS(TICKS)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .cathode     (cathode),
      .anode       (anode),
      .frame_done  (frame_done),
      .shown_value (shown_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] value);
      wr_en   = 1'b1;
      wr_data = value;
      stepCycle(1);
      wr_en   = 1'b0;
   endtask

   task automatic waitFrameDone(input string tag);
      int n;
      n = 0;
      do begin
         stepCycle(1);
         n++;
      end while (frame_done !== 1'b1 && n < 40);
      checkOutput({tag, "_frame_seen"}, {31'h0, frame_done}, 32'h1);
   endtask

   // Starts one sample after a wrap (or reset release) edge; ends on the next wrap sample.
   task automatic scanFrame(input string tag, input logic [31:0] value);
      int         msd;
      logic [7:0] exp_an;
      logic [6:0] exp_cath;
      msd = 0;
`ifdef SEVSEG_BLANK_EN
      for (int i = 1; i < 8; i++) if (value[4*i +: 4] != 4'h0) msd = i;
`else
      msd = 7;
`endif
      checkOutput({tag, "_shown"}, shown_value, value);
      stepCycle(1);
      for (int d = 0; d < 8; d++) begin
         if (d > msd) begin
            exp_an   = 8'hFF;
            exp_cath = 7'h7F;
         end else begin
            exp_an   = ~(8'b1 << d);
            exp_cath = font[value[4*d +: 4]];
         end
         checkOutput($sformatf("%s_an%0d", tag, d), {24'h0, anode}, {24'h0, exp_an});
         checkOutput($sformatf("%s_cath%0d", tag, d), {25'h0, cathode}, {25'h0, exp_cath});
         if (d < 7) stepCycle(TICKS);
      end
      stepCycle(TICKS - 1);
      checkOutput({tag, "_wrap"}, {31'h0, frame_done}, 32'h1);
   endtask

   initial begin
      font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      error_count = 0;
      check_count = 0;
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = 32'h0;

      stepCycle(3);
      checkOutput("rst_anode", {24'h0, anode}, 32'hFF);
      checkOutput("rst_cathode", {25'h0, cathode}, 32'h7F);
      checkOutput("rst_frame_done", {31'h0, frame_done}, 32'h0);
      rst = 1'b0;
      scanFrame("boot", 32'h0);
      stepCycle(1);
      checkOutput("boot_frame_pulse", {31'h0, frame_done}, 32'h0);
      checkOutput("boot_next_anode", {24'h0, anode}, 32'hFE);

      // Mid-frame write is held until the wrap.
      stepCycle(1);
      applyStimulus(32'h1234ABCD);
      checkOutput("hold_shown", shown_value, 32'h0);
      checkOutput("hold_cathode", {25'h0, cathode}, 32'h40);
      waitFrameDone("w1");
      scanFrame("w1", 32'h1234ABCD);

      // Last write in a frame wins.
      stepCycle(3);
      applyStimulus(32'h11111111);
      stepCycle(2);
      applyStimulus(32'h22222222);
      waitFrameDone("w2");
      scanFrame("w2", 32'h22222222);

      // Write landing on the wrap cycle is deferred one frame.
      stepCycle(2);
      applyStimulus(32'h33333333);
      stepCycle(28);
      applyStimulus(32'h44444444);
      checkOutput("coincide_wrap", {31'h0, frame_done}, 32'h1);
      scanFrame("w3", 32'h33333333);
      scanFrame("w4", 32'h44444444);

      // Reset mid-frame while digit 5 is lit, with a write still pending.
      applyStimulus(32'hFFFFFFFF);
      waitFrameDone("w5");
      stepCycle(21);
      checkOutput("mid_anode5", {24'h0, anode}, 32'hDF);
      checkOutput("mid_cathode5", {25'h0, cathode}, 32'h0E);
      applyStimulus(32'h12345678);
      rst = 1'b1;
      stepCycle(1);
      checkOutput("mrst_anode", {24'h0, anode}, 32'hFF);
      checkOutput("mrst_cathode", {25'h0, cathode}, 32'h7F);
      checkOutput("mrst_shown", shown_value, 32'h0);
      rst = 1'b0;
      scanFrame("mrst", 32'h0);
      stepCycle(1);
      checkOutput("mrst_pend_dropped", shown_value, 32'h0);

      // Leading-zero handling depends on the build.
      applyStimulus(32'h000000A5);
      waitFrameDone("blank");
      scanFrame("blank", 32'h000000A5);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Display back-end of the CPU_FPGA top level. Consumes the 32-bit value the processor writes to its memory-mapped display register and drives the 8-digit multiplexed seven-segment display (cathode/anode pins) at a fixed per-digit refresh rate. A write is held pending and committed only at a frame boundary, so a digit never shows a mix of old and new values.

Parameters:
DIGIT_TICKS, 100000, clk cycles each digit is lit (1 ms at 100 MHz); legal range >= 1
TICK_W, $clog2(DIGIT_TICKS+1), width of the prescale counter (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  single-cycle write strobe from the processor store path
wr_data  in  32  value to display, 8 hex nibbles; nibble d is shown on digit d
cathode  out  7  active-low segments {g,f,e,d,c,b,a}
anode  out  8  active-low digit enables; anode[d] drives digit d
frame_done  out  1  one-cycle pulse when digit 7 -> 0 wrap occurs
shown_value  out  32  value currently being scanned (disp register)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State: tick_cnt[TICK_W], digit[3], disp[32], pend[32], pend_valid.
- Reset values: tick_cnt=0, digit=0, disp=0, pend=0, pend_valid=0, anode=8'hFF, cathode=7'h7F, frame_done=0.
- Reset wins over all other inputs on the same edge, including mid-frame. All state returns to the reset values.
- Prescaler:
  - tick_cnt increments each cycle.
  - At DIGIT_TICKS-1, tick_cnt clears to 0 and digit advances; digit 7 wraps to 0.
  - With DIGIT_TICKS=1, digit advances every cycle.
- Outputs are registered, with 1 cycle latency from digit/disp:
  - anode = ~(8'b1 << digit)
  - cathode = SEG_LUT[disp[4*digit+:4]]
  - The first cycle after reset release still shows the reset values. The next cycle shows digit 0.
- Write handshake:
  - wr_en loads pend<=wr_data and sets pend_valid=1. There is no backpressure.
  - Multiple writes within one frame: the last write wins.
- Commit:
  - On the wrap cycle (digit 7 -> 0), frame_done is registered high for one cycle.
  - If pend_valid, then disp<=pend and pend_valid<=0.
- Simultaneous wr_en and wrap: disp takes the old pend. wr_data goes to pend with pend_valid=1 and is committed at the next wrap.
- Write with no pending value: shown from the next frame start. Worst-case latency is 8*DIGIT_TICKS+1 cycles.
- shown_value = disp.

Optional Feature:
Macro SEVSEG_BLANK_EN enables leading-zero blanking.
- Defined:
  - Every digit above the most-significant nonzero nibble of disp drives anode bit 1 (off) and cathode 7'h7F.
  - Digit 0 is never blanked, so disp=0 shows a single "0".
  - The scan timing is unchanged: blanked digits still occupy their slot.
- Undefined: all 8 digits are always lit, with zeros shown.

Decomposition:
- Package sevseg_pkg:
  - NUM_DIGITS=8.
  - Localparam SEG_LUT[16] of 7-bit active-low codes, {g..a}: 0:7'h40, 1:7'h79, 2:7'h24, 3:7'h30, 4:7'h19, 5:7'h12, 6:7'h02, 7:7'h78, 8:7'h00, 9:7'h10, A:7'h08, b:7'h03, C:7'h46, d:7'h21, E:7'h06, F:7'h0E.
  - SEG_OFF=7'h7F and AN_OFF=8'hFF.
- Sub-module: hex_to_7seg, a combinational nibble -> cathode lookup from SEG_LUT.
- The scanner holds all sequential logic.

Test Plan:
All scenarios use DIGIT_TICKS=4.
- Reset: hold rst 3 cycles -> anode=8'hFF, cathode=7'h7F, frame_done=0. Two cycles after release -> anode=8'hFE, cathode=7'h40. Digit advances every 4 cycles: FE, FD, FB, ... 7F, FE.
- Write 32'h1234ABCD mid-frame -> no change until frame_done. Next frame: digit0 anode=FE cathode=7'h21 ("d"); digit3 cathode=7'h08 ("A"); digit7 anode=7F cathode=7'h79 ("1"). shown_value=32'h1234ABCD.
- Writes 32'h11111111 then 32'h22222222 in the same frame -> every digit of the next frame shows 7'h24. 32'h11111111 never appears.
- Pending 32'h33333333, then wr_en with 32'h44444444 on the wrap cycle -> next frame shows 7'h30 on all digits. The frame after shows 7'h19.
- rst asserted for 1 cycle while digit 5 is lit with disp=32'hFFFFFFFF -> next edge anode=FF, cathode=7F, shown_value=0, pend_valid cleared. The scan restarts at digit 0 showing 7'h40.
- disp=32'h000000A5. With SEVSEG_BLANK_EN, digits 2..7 slots show anode=FF and cathode=7F. Without it, those digits show cathode=7'h40 with their anode bit low. Both builds show 7'h12 on digit 0 and 7'h08 on digit 1.
